// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared types and constants for the nibble-serial adder.
//   state_t - sequencer FSM states (IDLE, ADD, DONE)
//   NIB     - width of the shared adder slice
//   cnt_w() - nibble counter width for a given operand width
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB = 4;

    // clog2(WIDTH/4), floored at 1 so the counter never collapses to zero bits.
    function automatic int cnt_w(input int width);
        return (width / NIB > 1) ? $clog2(width / NIB) : 1;
    endfunction

endpackage

// File: rtl/add_seq_add4.sv
// add_seq_add4: 4-bit ripple adder built from four full-adder bit cells.
// Besides the sum and carry-out it exposes the carry out of bit 2 (the
// carry into bit 3), which the sequencer needs for signed overflow.
//   a, b  in  4  addends
//   ci    in  1  carry in
//   s     out 4  sum
//   co    out 1  carry out of bit 3
//   c3    out 1  carry into bit 3
module add_seq_add4
    import add_seq_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           ci,
    output logic [NIB-1:0] s,
    output logic           co,
    output logic           c3
);

    logic [NIB:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIB; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[NIB];
    assign c3 = c[NIB-1];

endmodule

// File: rtl/add_seq.sv
// add_seq: nibble-serial adder sequencer. Computes a + b + ci over WIDTH
// bits by stepping one shared 4-bit ripple adder across the operands,
// least-significant nibble first, over WIDTH/4 cycles.
//   clk, rst  clock, synchronous active-high reset
//   start     request, sampled in IDLE or DONE only
//   a, b, ci  operands, captured on an accepted start
//   sub       (ADD_SEQ_SUB_EN only) compute a - b instead
//   busy      high while nibbles are being summed
//   done      one-cycle pulse; s, co, v valid
//   s, co, v  sum, carry out, signed overflow; held until the next done
// Optional feature macro: ADD_SEQ_SUB_EN adds the sub port.
module add_seq
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             v
);

    localparam int N  = WIDTH / NIB;
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res;

    // Operand conditioning at capture time: subtraction is a + ~b + 1.
    logic [WIDTH-1:0] b_in;
    logic             ci_in;

`ifdef ADD_SEQ_SUB_EN
    always_comb begin
        b_in  = sub ? ~b : b;
        ci_in = sub | ci;
    end
`else
    always_comb begin
        b_in  = b;
        ci_in = ci;
    end
`endif

    // Operand registers shift right one nibble per ADD cycle, so the
    // adder always sees the low nibble and no wide mux is needed.
    logic [NIB-1:0] nib_s;
    logic           nib_co;
    logic           nib_c3;

    add_seq_add4 u_add4 (
        .a  (a_q[NIB-1:0]),
        .b  (b_q[NIB-1:0]),
        .ci (cy),
        .s  (nib_s),
        .co (nib_co),
        .c3 (nib_c3)
    );

    // Result fills from the top; after N shifts the first nibble is at bit 0.
    logic [WIDTH-1:0] res_nxt;
    assign res_nxt = {nib_s, res[WIDTH-1:NIB]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cy    <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            res   <= '0;
            s     <= '0;
            co    <= 1'b0;
            v     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE accepts like IDLE to allow back-to-back operations.
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b_in;
                        cy    <= ci_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ADD: begin
                    a_q <= a_q >> NIB;
                    b_q <= b_q >> NIB;
                    res <= res_nxt;
                    cy  <= nib_co;
                    if (cnt == LAST) begin
                        s     <= res_nxt;
                        co    <= nib_co;
                        v     <= nib_c3 ^ nib_co;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
